// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap sequencer: FSM state codes, trap kind,
// mcause codes and machine-mode CSR addresses.
package trap_ctrl_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CAPTURE  = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  typedef enum logic {
    KIND_ENTRY  = 1'b0,
    KIND_RETURN = 1'b1
  } trap_kind_e;

  localparam int unsigned CNT_W = 4;

  // Exception codes as reported in mcause[30:0]; interrupt bit lives above.
  localparam logic [30:0] MCAUSE_ECALL_U = 31'd8;
  localparam logic [30:0] MCAUSE_ECALL_S = 31'd9;
  localparam logic [30:0] MCAUSE_ECALL_M = 31'd11;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  function automatic logic [30:0] cause_code(input int code);
    return 31'(code);
  endfunction

endpackage

// File: rtl/trap_drain_cnt.sv
// Loadable 4-bit down-counter for the trap drain window. Holds while stalled,
// never counts below 1, and flags the terminal value 1.
module trap_drain_cnt
  import trap_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load has priority, decrement saturates at 1.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q > 4'd1)) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == 4'd1);

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: ecall (and, with TRAP_MRET_EN defined, mret) in EX ->
// CSR capture strobe -> pipeline drain -> fetch redirect to mtvec / mepc.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int ECALL_CAUSE  = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_ecall_ex,
  input  logic        cmd_mret_ex,
  input  logic [29:0] pc_ex,
  input  logic [29:0] csr_mtvec_ex,
  input  logic [29:0] csr_mepc_ex,
  input  logic        stall,
  output logic        trap_capture,
  output logic [29:0] trap_epc,
  output logic [30:0] trap_cause,
  output logic        trap_flush,
  output logic        trap_jmp,
  output logic [29:0] trap_pc,
  output logic        trap_busy
);

  localparam logic [CNT_W-1:0] FLUSH_LD = 4'(FLUSH_CYCLES);
  localparam logic [30:0]      CAUSE_C  = cause_code(ECALL_CAUSE);

  logic [1:0]  state_q, state_d;
  logic [29:0] epc_q, epc_d;
  logic        cnt_load_s, cnt_dec_s, cnt_term_s;
  logic        capture_s, jmp_s, busy_s;
  logic [29:0] target_s;

`ifdef TRAP_MRET_EN
  trap_kind_e  kind_q, kind_d;
`endif

  // Sequencer next-state, epc latch and kind selection.
  always_comb begin
    state_d    = state_q;
    epc_d      = epc_q;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
`ifdef TRAP_MRET_EN
    kind_d     = kind_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!stall && cmd_ecall_ex) begin
          epc_d   = pc_ex;
          state_d = ST_CAPTURE;
`ifdef TRAP_MRET_EN
          kind_d  = KIND_ENTRY;
        end else if (!stall && cmd_mret_ex) begin
          kind_d  = KIND_RETURN;
          state_d = ST_CAPTURE;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      // The strobe must stay exactly one cycle, so stall is not consulted here.
      ST_CAPTURE: begin
        cnt_load_s = 1'b1;
        if (FLUSH_LD == 4'd0) begin
          state_d = ST_REDIRECT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!stall) begin
          cnt_dec_s = 1'b1;
          if (cnt_term_s) begin
            state_d = ST_REDIRECT;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_REDIRECT: begin
        if (!stall) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REDIRECT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      epc_q   <= 30'd0;
`ifdef TRAP_MRET_EN
      kind_q  <= KIND_ENTRY;
`endif
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
`ifdef TRAP_MRET_EN
      kind_q  <= kind_d;
`endif
    end
  end

  trap_drain_cnt u_drain_cnt (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .load_i     (cnt_load_s),
    .load_val_i (FLUSH_LD),
    .dec_i      (cnt_dec_s),
    .term_o     (cnt_term_s)
  );

  // Target is read live so a CSR write retired during the drain is honoured.
`ifdef TRAP_MRET_EN
  assign capture_s = (state_q == ST_CAPTURE) && (kind_q == KIND_ENTRY);
  assign target_s  = (kind_q == KIND_RETURN) ? csr_mepc_ex : csr_mtvec_ex;
`else
  logic unused_mret_s;
  assign capture_s     = (state_q == ST_CAPTURE);
  assign target_s      = csr_mtvec_ex;
  assign unused_mret_s = ^{cmd_mret_ex, csr_mepc_ex};
`endif

  assign busy_s = (state_q != ST_IDLE);
  assign jmp_s  = (state_q == ST_REDIRECT);

  assign trap_capture = capture_s;
  assign trap_epc     = epc_q;
  assign trap_cause   = capture_s ? CAUSE_C : 31'd0;
  assign trap_flush   = busy_s;
  assign trap_jmp     = jmp_s;
  assign trap_pc      = jmp_s ? target_s : 30'd0;
  assign trap_busy    = busy_s;

endmodule
